// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the label-RAM controller: clear FSM states,
// requester ids and default widths.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_LEN_DEF = 16;
  localparam int unsigned DATA_LEN_DEF = 8;
  localparam int unsigned WAIT_LEN     = 16;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear-sweep sequencer: walks the label range 0..CLR_LAST writing zeros,
// then pulses done for one cycle. All outputs come straight from flops.
module ram_clr_seq
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_LEN = ADDR_LEN_DEF,
  parameter int unsigned CLR_LAST = (32'd1 << ADDR_LEN) - 32'd1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  output logic                o_wr_en,
  output logic [ADDR_LEN-1:0] o_addr,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(CLR_LAST);

  clr_state_e          r_state;
  clr_state_e          w_state_nxt;
  logic [ADDR_LEN-1:0] r_cnt;
  logic [ADDR_LEN-1:0] w_cnt_nxt;
  logic                r_wr_en;
  logic                r_busy;
  logic                r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wr_en <= (w_state_nxt == CLEAR);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Compare before incrementing so an all-ones last address never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_LEN'(1);
        if (r_cnt == LAST_ADDR) w_state_nxt = DONE;
      end
      DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_wr_en = r_wr_en;
  assign o_addr  = r_cnt;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the label RAM between wavefront (A) and
// trace-back (B), with the clear sweep muxed onto the write port.
// Optional wait counters are enabled by defining RAM_ARB_STATS_EN.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_LEN = ADDR_LEN_DEF,
  parameter int unsigned DATA_LEN = DATA_LEN_DEF,
  parameter int unsigned CLR_LAST = (32'd1 << ADDR_LEN) - 32'd1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                clr_done,
  input  logic                a_req,
  input  logic                b_req,
  input  logic                a_we,
  input  logic                b_we,
  input  logic [ADDR_LEN-1:0] a_addr,
  input  logic [ADDR_LEN-1:0] b_addr,
  input  logic [DATA_LEN-1:0] a_wdata,
  input  logic [DATA_LEN-1:0] b_wdata,
  output logic                a_gnt,
  output logic                b_gnt,
  output logic                a_rvalid,
  output logic                b_rvalid,
  output logic [DATA_LEN-1:0] rd_data,
  output logic                ram_wr_en,
  output logic [ADDR_LEN-1:0] ram_wr_addr,
  output logic [DATA_LEN-1:0] ram_wr_data,
  output logic [ADDR_LEN-1:0] ram_rd_addr,
  input  logic [DATA_LEN-1:0] ram_rd_data
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [WAIT_LEN-1:0] a_wait_cnt,
  output logic [WAIT_LEN-1:0] b_wait_cnt
`endif
);

  logic                w_seq_wr_en;
  logic [ADDR_LEN-1:0] w_seq_addr;
  logic                w_seq_busy;
  logic                w_seq_done;

  logic                r_last_id;
  logic [ADDR_LEN-1:0] r_rd_addr;
  logic                r_a_rvalid;
  logic                r_b_rvalid;

  logic                w_arb_en;
  logic                w_a_win;
  logic                w_b_win;
  logic                w_win_we;
  logic [ADDR_LEN-1:0] w_win_addr;
  logic [DATA_LEN-1:0] w_win_wdata;
  logic                w_rd_issue;
  logic                w_wr_issue;

  ram_clr_seq #(
    .ADDR_LEN (ADDR_LEN),
    .CLR_LAST (CLR_LAST)
  ) u_clr_seq (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_start (clr_start),
    .o_wr_en (w_seq_wr_en),
    .o_addr  (w_seq_addr),
    .o_busy  (w_seq_busy),
    .o_done  (w_seq_done)
  );

  // Grants only in idle; a pending clr_start beats both requesters.
  always_comb begin
    w_arb_en    = RST_N & ~w_seq_busy & ~clr_start;
    w_a_win     = w_arb_en & a_req & (~b_req | (r_last_id == REQ_B));
    w_b_win     = w_arb_en & b_req & ~w_a_win;
    w_win_we    = w_a_win ? a_we    : b_we;
    w_win_addr  = w_a_win ? a_addr  : b_addr;
    w_win_wdata = w_a_win ? a_wdata : b_wdata;
    w_rd_issue  = (w_a_win | w_b_win) & ~w_win_we;
    w_wr_issue  = (w_a_win | w_b_win) & w_win_we;
  end

  always_comb begin
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    if (RST_N && w_seq_wr_en) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = w_seq_addr;
    end else if (w_wr_issue) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = w_win_addr;
      ram_wr_data = w_win_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_last_id  <= REQ_B;
      r_rd_addr  <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      if (w_a_win)      r_last_id <= REQ_A;
      else if (w_b_win) r_last_id <= REQ_B;
      if (w_rd_issue)   r_rd_addr <= w_win_addr;
      r_a_rvalid <= w_a_win & ~a_we;
      r_b_rvalid <= w_b_win & ~b_we;
    end
  end

  assign a_gnt       = w_a_win;
  assign b_gnt       = w_b_win;
  assign ram_rd_addr = w_rd_issue ? w_win_addr : r_rd_addr;
  assign a_rvalid    = r_a_rvalid;
  assign b_rvalid    = r_b_rvalid;
  // RAM data lands the cycle after the address, so it is passed through here.
  assign rd_data     = (r_a_rvalid | r_b_rvalid) ? ram_rd_data : '0;
  assign clr_busy    = w_seq_busy;
  assign clr_done    = w_seq_done;

`ifdef RAM_ARB_STATS_EN
  logic [WAIT_LEN-1:0] r_a_wait;
  logic [WAIT_LEN-1:0] r_b_wait;

  always_ff @(posedge CLK) begin
    if (!RST_N || w_seq_done) begin
      r_a_wait <= '0;
      r_b_wait <= '0;
    end else begin
      if (a_req && !w_a_win && !(&r_a_wait)) r_a_wait <= r_a_wait + WAIT_LEN'(1);
      if (b_req && !w_b_win && !(&r_b_wait)) r_b_wait <= r_b_wait + WAIT_LEN'(1);
    end
  end

  assign a_wait_cnt = r_a_wait;
  assign b_wait_cnt = r_b_wait;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a label-level model predicts grants, RAM
// writes and read responses; a separate monitor retires read responses.
module tb_ram_arbiter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int          CLR_N = 16;
  localparam int          NADDR = 32;
  localparam int          DEPTH = 1 << AW;

  typedef struct {
    bit             owner_b;
    logic [DW-1:0]  data;
    int unsigned    due;
  } rd_exp_t;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          clr_start;
  logic          clr_busy, clr_done;
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] rd_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   a_wait_cnt, b_wait_cnt;
  logic [15:0]   m_wa, m_wb;
`endif

  ram_arbiter #(
    .ADDR_LEN (AW),
    .DATA_LEN (DW),
    .CLR_LAST (32'(CLR_N - 1))
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .a_req       (a_req),
    .b_req       (b_req),
    .a_we        (a_we),
    .b_we        (b_we),
    .a_addr      (a_addr),
    .b_addr      (b_addr),
    .a_wdata     (a_wdata),
    .b_wdata     (b_wdata),
    .a_gnt       (a_gnt),
    .b_gnt       (b_gnt),
    .a_rvalid    (a_rvalid),
    .b_rvalid    (b_rvalid),
    .rd_data     (rd_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
`ifdef RAM_ARB_STATS_EN
    ,
    .a_wait_cnt  (a_wait_cnt),
    .b_wait_cnt  (b_wait_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 32'd1;

  // Behavioural RAM macro with a preload path used only during reset.
  logic [DW-1:0] ram [DEPTH];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge CLK) begin
    if (ram_wr_en)   ram[ram_wr_addr] <= ram_wr_data;
    else if (pre_we) ram[pre_addr]    <= pre_data;
    ram_rd_data <= ram[ram_rd_addr];
  end

  // Reference model state
  logic [DW-1:0] shadow [DEPTH];
  int            m_clr;
  bit            m_last_b;
  logic [AW-1:0] m_rd_addr;
  rd_exp_t       q[$];

  bit            obs_a_gnt, obs_b_gnt, obs_busy, obs_done, obs_wen;
  logic [AW-1:0] obs_waddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Checks one cycle of combinational and registered outputs against the model.
  task automatic step(output bit ga, output bit gb);
    bit            busy_e, done_e, wen_e, win_we;
    logic [AW-1:0] waddr_e, win_addr;
    logic [DW-1:0] wdata_e, win_data;
    ga = 1'b0; gb = 1'b0; busy_e = 1'b0; done_e = 1'b0; wen_e = 1'b0;
    waddr_e = '0; wdata_e = '0; win_we = 1'b0; win_addr = '0; win_data = '0;
    #1;
    obs_a_gnt = a_gnt; obs_b_gnt = b_gnt; obs_busy = clr_busy;
    obs_done = clr_done; obs_wen = ram_wr_en; obs_waddr = ram_wr_addr;
    if (!RST_N) begin
      chk("a_gnt_in_reset", 32'(a_gnt), 32'd0);
      chk("b_gnt_in_reset", 32'(b_gnt), 32'd0);
      chk("ram_wr_en_in_reset", 32'(ram_wr_en), 32'd0);
      m_clr = -1; m_last_b = 1'b1; m_rd_addr = '0; q.delete();
`ifdef RAM_ARB_STATS_EN
      m_wa = '0; m_wb = '0;
`endif
    end else begin
      busy_e = (m_clr >= 0);
      done_e = (m_clr == CLR_N);
      if (m_clr >= 0 && m_clr < CLR_N) begin
        wen_e   = 1'b1;
        waddr_e = AW'(m_clr);
        shadow[AW'(m_clr)] = '0;
      end
      if (m_clr < 0 && !clr_start) begin
        ga = a_req && (!b_req || m_last_b);
        gb = b_req && !ga;
      end
      if (ga || gb) begin
        win_we   = ga ? a_we    : b_we;
        win_addr = ga ? a_addr  : b_addr;
        win_data = ga ? a_wdata : b_wdata;
        m_last_b = gb;
        if (win_we) begin
          wen_e = 1'b1; waddr_e = win_addr; wdata_e = win_data;
          shadow[win_addr] = win_data;
        end else begin
          q.push_back('{owner_b: gb, data: shadow[win_addr], due: cyc + 32'd1});
          m_rd_addr = win_addr;
        end
      end
      chk("a_gnt", 32'(a_gnt), 32'(ga));
      chk("b_gnt", 32'(b_gnt), 32'(gb));
      chk("ram_wr_en", 32'(ram_wr_en), 32'(wen_e));
      if (wen_e) begin
        chk("ram_wr_addr", 32'(ram_wr_addr), 32'(waddr_e));
        chk("ram_wr_data", 32'(ram_wr_data), 32'(wdata_e));
      end
      chk("ram_rd_addr", 32'(ram_rd_addr), 32'(m_rd_addr));
      chk("clr_busy", 32'(clr_busy), 32'(busy_e));
      chk("clr_done", 32'(clr_done), 32'(done_e));
`ifdef RAM_ARB_STATS_EN
      chk("a_wait_cnt", 32'(a_wait_cnt), 32'(m_wa));
      chk("b_wait_cnt", 32'(b_wait_cnt), 32'(m_wb));
      if (done_e) begin
        m_wa = '0; m_wb = '0;
      end else begin
        if (a_req && !ga && m_wa != 16'hFFFF) m_wa = m_wa + 16'd1;
        if (b_req && !gb && m_wb != 16'hFFFF) m_wb = m_wb + 16'd1;
      end
`endif
      if (m_clr < 0) begin
        if (clr_start) m_clr = 0;
      end else if (m_clr == CLR_N) begin
        m_clr = -1;
      end else begin
        m_clr = m_clr + 1;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    clr_start = 1'b0; a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
  endtask

  task automatic do_reset(input int n);
    bit ga, gb;
    idle_inputs();
    RST_N = 1'b0;
    repeat (n) step(ga, gb);
    RST_N = 1'b1;
  endtask

  // Issue one access and hold the request until granted (bounded).
  task automatic access(input bit use_b, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    bit ga, gb, ok;
    int tries;
    ok = 1'b0; tries = 0;
    if (use_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data; end
    else       begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data; end
    while (!ok && tries < 8) begin
      step(ga, gb);
      tries++;
      ok = use_b ? (gb && obs_b_gnt) : (ga && obs_a_gnt);
    end
    chk("access_granted", 32'(ok), 32'd1);
    if (use_b) b_req = 1'b0; else a_req = 1'b0;
  endtask

  // Monitor: retires read responses in order and checks owner, data and latency.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (RST_N === 1'b1) begin
        if (a_rvalid || b_rvalid) begin
          if (q.size() == 0) begin
            chk("rvalid_unexpected", 32'({a_rvalid, b_rvalid}), 32'd0);
          end else begin
            e = q.pop_front();
            chk("rvalid_owner", 32'({a_rvalid, b_rvalid}), e.owner_b ? 32'd1 : 32'd2);
            chk("rd_data", 32'(rd_data), 32'(e.data));
            chk("rvalid_latency", cyc, e.due);
          end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          chk("rvalid_missing", 32'({a_rvalid, b_rvalid}), e.owner_b ? 32'd1 : 32'd2);
        end
      end
    end
  end

  initial begin
    bit ga, gb;
    int busy_n, done_n, first_gnt, guard;
    logic [1:0] seq_exp [4];
    seq_exp[0] = 2'b10; seq_exp[1] = 2'b01; seq_exp[2] = 2'b10; seq_exp[3] = 2'b01;

    idle_inputs();
    RST_N = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    m_clr = -1; m_last_b = 1'b1; m_rd_addr = '0;
`ifdef RAM_ARB_STATS_EN
    m_wa = '0; m_wb = '0;
`endif
    // Preload labels while held in reset.
    for (int i = 0; i < NADDR; i++) begin
      pre_we = 1'b1; pre_addr = AW'(i); pre_data = DW'($urandom);
      shadow[i] = pre_data;
      step(ga, gb);
    end
    pre_we = 1'b0;
    step(ga, gb);
    RST_N = 1'b1;
    #1;
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_clr_done", 32'(clr_done), 32'd0);
    chk("rst_rvalids", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_ram_rd_addr", 32'(ram_rd_addr), 32'd0);

    // Clear sweep, with an A read arriving in sweep cycle 3.
    clr_start = 1'b1;
    step(ga, gb);
    clr_start = 1'b0;
    busy_n = 0; done_n = 0; first_gnt = -1;
    for (int i = 0; i < 22; i++) begin
      if (i == 2) begin a_req = 1'b1; a_we = 1'b0; a_addr = 8'd20; end
      step(ga, gb);
      busy_n += int'(obs_busy);
      done_n += int'(obs_done);
      if (obs_a_gnt && first_gnt < 0) first_gnt = i;
      if (ga) a_req = 1'b0;
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'd17);
    chk("clr_done_pulses", 32'(done_n), 32'd1);
    chk("gnt_after_clear_cycle", 32'(first_gnt), 32'd17);

    // Round-robin contention straight after reset.
    do_reset(2);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'd20;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'd21;
    for (int i = 0; i < 4; i++) begin
      step(ga, gb);
      chk("contention_order", 32'({obs_a_gnt, obs_b_gnt}), 32'(seq_exp[i]));
    end
    idle_inputs();
    step(ga, gb);

    // Writes through B, then solo reads by A.
    access(1'b1, 1'b1, 8'd5, 8'h23);
    access(1'b0, 1'b0, 8'd5, 8'h00);
    access(1'b1, 1'b1, 8'd7, 8'h04);
    access(1'b0, 1'b0, 8'd7, 8'h00);
    step(ga, gb);

    // Reset while the sweep is at address 6, then restart.
    clr_start = 1'b1;
    step(ga, gb);
    clr_start = 1'b0;
    guard = 0;
    while (m_clr != 6 && guard < 40) begin
      step(ga, gb);
      guard++;
    end
    chk("sweep_reached_6", 32'(obs_waddr), 32'd5);
    RST_N = 1'b0;
    step(ga, gb);
    RST_N = 1'b1;
    step(ga, gb);
    chk("rst_mid_clear_busy", 32'(obs_busy), 32'd0);
    chk("rst_mid_clear_done", 32'(obs_done), 32'd0);
    clr_start = 1'b1;
    step(ga, gb);
    clr_start = 1'b0;
    step(ga, gb);
    chk("restart_wr_en", 32'(obs_wen), 32'd1);
    chk("restart_addr", 32'(obs_waddr), 32'd0);
    repeat (18) step(ga, gb);

    // Randomized traffic with occasional clear requests.
    for (int n = 0; n < 1200; n++) begin
      clr_start = ($urandom_range(0, 59) == 0);
      if (!a_req && $urandom_range(0, 99) < 55) begin
        a_req = 1'b1; a_we = ($urandom_range(0, 2) == 0);
        a_addr = AW'($urandom_range(0, NADDR - 1)); a_wdata = DW'($urandom);
      end
      if (!b_req && $urandom_range(0, 99) < 55) begin
        b_req = 1'b1; b_we = ($urandom_range(0, 3) == 0);
        b_addr = AW'($urandom_range(0, NADDR - 1)); b_wdata = DW'($urandom);
      end
      step(ga, gb);
      if (ga) a_req = 1'b0;
      if (gb) b_req = 1'b0;
    end
    idle_inputs();
    repeat (3) step(ga, gb);
    chk("rd_queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequences and shares the single-port-per-direction label RAM (one write port, one synchronous read port) used by the maze-routing datapath.
- Arbitrates two requesters, round-robin:
  - A: wavefront expansion, which reads and writes labels.
  - B: trace-back, which reads labels.
- Owns the clear sweep that zeroes the label range before each routing pass.
- Sits between requesters and the RAM macro; replaces ad-hoc address muxing with a granted, handshaked access path.

Parameters:
- ADDR_LEN, 16, RAM address width.
- DATA_LEN, 8, label width.
- CLR_LAST, 2**ADDR_LEN-1, last address written by the clear sweep (reduced in sim).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- clr_start  in  1  pulse; begin clear sweep.
- clr_busy  out  1  high while sweep active.
- clr_done  out  1  one-cycle pulse after last clear write.
- a_req, b_req  in  1  access request; held until granted.
- a_we, b_we  in  1  1 = write, 0 = read; valid with req.
- a_addr, b_addr  in  ADDR_LEN  access address.
- a_wdata, b_wdata  in  DATA_LEN  write data.
- a_gnt, b_gnt  out  1  combinational grant; access is issued this cycle.
- a_rvalid, b_rvalid  out  1  read data valid for that requester.
- rd_data  out  DATA_LEN  read data, qualified by the rvalid strobes.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_LEN  RAM write address.
- ram_wr_data  out  DATA_LEN  RAM write data.
- ram_rd_addr  out  ADDR_LEN  RAM read address.
- ram_rd_data  in  DATA_LEN  RAM read data, 1 cycle after ram_rd_addr.

Behaviour:
- Reset (RST_N=0 at posedge):
  - state=IDLE, clear counter=0, priority pointer=B (so A wins the first tie).
  - clr_busy=0, clr_done=0, rvalids=0.
  - ram_rd_addr=0, rd_data=0.
  - Combinational outputs (gnt, ram_wr_*) forced 0 while RST_N=0.
- FSM states:
  - IDLE: clr_start=1 -> CLEAR next cycle. No grant in the clr_start cycle; clr_start wins over requests.
  - CLEAR: each cycle ram_wr_en=1, ram_wr_addr=counter, ram_wr_data=0, counter++.
    - Cycle writing CLR_LAST -> DONE.
    - clr_start ignored. No grants; requesters hold req.
  - DONE: clr_done=1 for exactly this cycle, counter cleared, no grants -> IDLE.
  - clr_busy=1 in CLEAR and DONE.
- Arbitration (IDLE only, clr_start=0):
  - Only one requester asserting req: granted.
  - Both asserting: the one not granted most recently wins.
  - Pointer updates on every grant.
  - Max wait under contention: 1 grant of the other requester.
- Granted write: same cycle ram_wr_en=1, ram_wr_addr/ram_wr_data from the winner. No rvalid.
- Granted read:
  - Same cycle ram_rd_addr=winner addr (registered hold value bypassed combinationally).
  - Next cycle winner's rvalid=1 and rd_data=ram_rd_data.
  - Back-to-back reads fully pipelined: 1 access/cycle.
- No grant: ram_wr_en=0; ram_rd_addr holds its last value.
- One access per cycle total. A read and a write from different requesters never issue in the same cycle.
- Counter width ADDR_LEN; CLR_LAST=all-ones terminates without wrap.
- RST_N=0 mid-CLEAR: sweep aborts, no clr_done, counter=0. Any in-flight rvalid is dropped.

Optional Feature:
- Macro RAM_ARB_STATS_EN.
- Defined: adds outputs a_wait_cnt and b_wait_cnt (16 bits each).
  - Counts cycles with req=1 and gnt=0, including during CLEAR.
  - Saturates at 16'hFFFF; cleared by reset and by clr_done.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state enum (IDLE, CLEAR, DONE).
  - Requester id constants REQ_A=0, REQ_B=1.
  - Default ADDR_LEN/DATA_LEN localparams.
- One sub-module, ram_clr_seq: counter plus CLEAR/DONE sequencing, exposing wr_en/addr/busy/done. The arbiter muxes its write port in.

Test Plan:
- Clear sweep, CLR_LAST=15: clr_start pulse -> 16 consecutive writes of 0 at addresses 0..15, clr_busy high 17 cycles, clr_done single pulse in cycle 18 after start.
- Solo read: A reads addr 5 where RAM holds 8'h23 -> a_gnt same cycle, ram_rd_addr=5, a_rvalid and rd_data=8'h23 next cycle, b_rvalid=0.
- Contention: both req continuously for 4 cycles after reset -> grants A,B,A,B; each rvalid returns to the correct owner.
- Write through B: b_we=1, addr 7, data 8'h04 -> ram_wr_en=1, addr 7, data 4 same cycle; no rvalid; subsequent A read of 7 returns 4.
- Request during clear: A req asserted in cycle 3 of sweep -> no grant until the cycle after clr_done, then granted. With RAM_ARB_STATS_EN, a_wait_cnt equals the stalled cycles.
- Reset mid-clear: RST_N low at counter=6 -> next cycle clr_busy=0, no clr_done. A new clr_start restarts the sweep from address 0.
